shared_vram_arbiter: RTL

//  Clocked successor of the two-CPU PAL video-RAM select decoder. Decodes the A15..A11 field of NUM_CPUS CPU buses

---
 rtl/svram_pkg.sv | 47 ++++
 rtl/svram_region_decode.sv | 36 +++
 rtl/shared_vram_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/svram_pkg.sv
// Shared video-RAM arbiter: region encodings, region-map entry layout and the default map
// reproducing the original two-CPU PAL decoder.
package svram_pkg;

  localparam int unsigned REG_FRONT = 0;
  localparam int unsigned REG_SIDE  = 1;
  localparam int unsigned REG_BACK1 = 2;

  localparam int unsigned MAP_CPU_W   = 4;
  localparam int unsigned MAP_MATCH_W = 5;
  localparam int unsigned MAP_REG_W   = 4;

  typedef struct packed {
    logic [MAP_CPU_W-1:0]   cpu_idx;
    logic [MAP_MATCH_W-1:0] match;
    logic [MAP_REG_W-1:0]   region_idx;
  } map_entry_t;

  localparam int unsigned MAP_ENTRY_W     = $bits(map_entry_t);
  localparam int unsigned DEFAULT_NUM_MAP = 10;

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} arb_state_e;

  function automatic map_entry_t map_entry(input int unsigned cpu, input logic [4:0] match,
                                           input int unsigned region);
    map_entry_t e;
    e.cpu_idx    = MAP_CPU_W'(cpu);
    e.match      = match;
    e.region_idx = MAP_REG_W'(region);
    return e;
  endfunction

  // match field is A15..A11 of the region base address
  localparam logic [DEFAULT_NUM_MAP*MAP_ENTRY_W-1:0] DEFAULT_MAP = {
    map_entry(1, 5'b11011, REG_BACK1),  // CPU1 D800
    map_entry(1, 5'b11100, REG_BACK1),  // CPU1 E000
    map_entry(1, 5'b11111, REG_SIDE),   // CPU1 F800
    map_entry(1, 5'b11001, REG_FRONT),  // CPU1 C800
    map_entry(1, 5'b11010, REG_FRONT),  // CPU1 D000
    map_entry(0, 5'b11101, REG_BACK1),  // CPU0 E800
    map_entry(0, 5'b11110, REG_BACK1),  // CPU0 F000
    map_entry(0, 5'b11111, REG_SIDE),   // CPU0 F800
    map_entry(0, 5'b11011, REG_FRONT),  // CPU0 D800
    map_entry(0, 5'b11100, REG_FRONT)   // CPU0 E000
  };

endpackage

// File: rtl/svram_region_decode.sv
// Combinational address decode for one CPU port: matches A15..A11 against the region map
// and reports whether the port requests a shared RAM and which region it hits.
module svram_region_decode
  import svram_pkg::*;
#(
  parameter int unsigned CPU_IDX     = 0,
  parameter int unsigned NUM_REGIONS = 3,
  parameter int unsigned NUM_MAP     = DEFAULT_NUM_MAP,
  parameter logic [NUM_MAP*MAP_ENTRY_W-1:0] MAP = DEFAULT_MAP,
  localparam int unsigned RegW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic            mreq_n_i,
  input  logic            e_addr_i,
  input  logic [4:0]      addr_hi_i,
  output logic            req_o,
  output logic [RegW-1:0] region_o
);

  map_entry_t entry;

  always_comb begin
    req_o    = 1'b0;
    region_o = '0;
    entry    = '0;
    // First matching entry wins; entries naming a non-existent region are ignored
    for (int m = 0; m < NUM_MAP; m++) begin
      entry = map_entry_t'(MAP[m*MAP_ENTRY_W +: MAP_ENTRY_W]);
      if (!req_o && !mreq_n_i && !e_addr_i && entry.cpu_idx == MAP_CPU_W'(CPU_IDX) &&
          entry.match == addr_hi_i && entry.region_idx < MAP_REG_W'(NUM_REGIONS)) begin
        req_o    = 1'b1;
        region_o = entry.region_idx[RegW-1:0];
      end
    end
  end

endmodule

// File: rtl/shared_vram_arbiter.sv
// Round-robin arbiter for the shared front/side/back video RAMs: decodes each CPU bus,
// grants one owner at a time and drives registered owner select, chip selects and read strobe.
module shared_vram_arbiter
  import svram_pkg::*;
#(
  parameter int unsigned NUM_CPUS    = 2,
  parameter int unsigned NUM_REGIONS = 3,
  parameter int unsigned NUM_MAP     = DEFAULT_NUM_MAP,
  parameter int unsigned ACC_CYCLES  = 2,
  parameter logic [NUM_MAP*MAP_ENTRY_W-1:0] MAP = DEFAULT_MAP,
  localparam int unsigned SelW = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CPUS-1:0]     mreq_n,
  input  logic [NUM_CPUS-1:0]     e_addr,
  input  logic [NUM_CPUS*5-1:0]   addr_hi,
  input  logic [NUM_CPUS-1:0]     rd_n,
  output logic [SelW-1:0]         sel,
  output logic [NUM_REGIONS-1:0]  cs_n,
  output logic                    vrd_n,
  output logic [NUM_CPUS-1:0]     wait_n
);

  localparam int unsigned RegW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int unsigned AccW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
  localparam logic [AccW-1:0] AccLast = AccW'(ACC_CYCLES - 1);

  logic [NUM_CPUS-1:0] req;
  logic [RegW-1:0]     region [NUM_CPUS];

  for (genvar g = 0; g < NUM_CPUS; g++) begin : g_decode
    svram_region_decode #(
      .CPU_IDX    (g),
      .NUM_REGIONS(NUM_REGIONS),
      .NUM_MAP    (NUM_MAP),
      .MAP        (MAP)
    ) u_decode (
      .mreq_n_i (mreq_n[g]),
      .e_addr_i (e_addr[g]),
      .addr_hi_i(addr_hi[5*g +: 5]),
      .req_o    (req[g]),
      .region_o (region[g])
    );
  end

  arb_state_e            state_q, state_d;
  logic [SelW-1:0]        sel_q, sel_d;
  logic [SelW-1:0]        rr_last_q, rr_last_d;
  logic [NUM_REGIONS-1:0] cs_n_q, cs_n_d;
  logic                   vrd_n_q, vrd_n_d;
  logic [AccW-1:0]        acc_cnt_q, acc_cnt_d;
  logic [RegW-1:0]        reg_q, reg_d;

  logic            found;
  logic [SelW-1:0] winner;
  logic [SelW-1:0] cand;

  // Cyclic search starting just after the last owner
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_CPUS; k++) begin
      cand = SelW'((int'(rr_last_q) + k) % NUM_CPUS);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_last_d = rr_last_q;
    cs_n_d    = cs_n_q;
    vrd_n_d   = vrd_n_q;
    acc_cnt_d = acc_cnt_q;
    reg_d     = reg_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d   = StGrant;
          sel_d     = winner;
          cs_n_d    = ~(NUM_REGIONS'(1) << region[winner]);
          vrd_n_d   = rd_n[winner];
          acc_cnt_d = '0;
          reg_d     = region[winner];
        end
      end
      StGrant: begin
        // A dropped request or a region change ends the access early
        if (acc_cnt_q == AccLast || !req[sel_q] || region[sel_q] != reg_q) begin
          state_d   = StRelease;
          cs_n_d    = '1;
          vrd_n_d   = 1'b1;
          rr_last_d = sel_q;
        end else begin
          acc_cnt_d = acc_cnt_q + 1'b1;
          vrd_n_d   = rd_n[sel_q];
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      rr_last_q <= SelW'(NUM_CPUS - 1);
      cs_n_q    <= '1;
      vrd_n_q   <= 1'b1;
      acc_cnt_q <= '0;
      reg_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rr_last_q <= rr_last_d;
      cs_n_q    <= cs_n_d;
      vrd_n_q   <= vrd_n_d;
      acc_cnt_q <= acc_cnt_d;
      reg_q     <= reg_d;
    end
  end

  // WAIT lifts only in the owner's final access cycle
  always_comb begin
    wait_n = '1;
    for (int i = 0; i < NUM_CPUS; i++) begin
      wait_n[i] = ~(req[i] & ~(state_q == StGrant && sel_q == SelW'(i) && acc_cnt_q == AccLast));
    end
  end

  assign sel   = sel_q;
  assign cs_n  = cs_n_q;
  assign vrd_n = vrd_n_q;

endmodule
